// File: rtl/accum_ctrl_banked.sv
// rtl/accum_ctrl_banked.sv - banked accumulator RMW command generator for systolic array output wavefronts
module accum_ctrl_banked #(
   parameter int MUL_SIZE  = 32,
   parameter int DIM_W     = 8,
   parameter int ADDR_W    = 10,
   parameter int NUM_BANKS = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           instr_valid_i,
   output logic                           instr_ready_o,
   input  logic [DIM_W-1:0]               instr_v_dim_i,
   input  logic [DIM_W-1:0]               instr_k_tiles_i,
   input  logic                           instr_accumulate_i,
   input  logic                           mac_out_valid_i,
   output logic                           acc_rd_en_o,
   output logic [ADDR_W-1:0]              acc_rd_addr_o,
   output logic [MUL_SIZE-1:0]            acc_rd_mask_o,
   output logic                           acc_wr_en_o,
   output logic [ADDR_W-1:0]              acc_wr_addr_o,
   output logic [MUL_SIZE-1:0]            acc_wr_mask_o,
   output logic                           acc_add_o,
   output logic                           bank_done_o,
   output logic [$clog2(NUM_BANKS)-1:0]   bank_done_id_o,
   input  logic                           bank_release_i,
   input  logic [$clog2(NUM_BANKS)-1:0]   bank_release_id_i,
   output logic                           instr_err_o
);

   localparam int BID_W      = $clog2(NUM_BANKS);
   localparam int BANK_DEPTH = (2 ** ADDR_W) / NUM_BANKS;
   localparam int ROW_W      = ADDR_W - BID_W;
   localparam int CNT_W      = DIM_W + $clog2(MUL_SIZE) + 1;

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       w_q, w_d, wlast_q, wlast_d;
   logic [DIM_W-1:0]       t_q, t_d, klast_q, klast_d;
   logic [DIM_W-1:0]       v_q, v_d;
   logic                   acc_q, acc_d;
   logic [BID_W-1:0]       bank_q, bank_d, next_bank_q, next_bank_d;
   logic [NUM_BANKS-1:0]   busy_q, busy_d;

   logic                   sample, wf_end, last_wf;
   logic                   accept, illegal, accept_ok, accept_err;
   logic [31:0]            w_total;
   logic                   add_now;
   logic [ADDR_W-1:0]      addr_now;
   logic [MUL_SIZE-1:0]    mask_now;

   logic                   p1_valid, p1_add, p1_last, p2_last;
   logic [BID_W-1:0]       p1_bank, p2_bank;

   // Wavefront bookkeeping; w_total is the wavefront count of the offered instruction.
   assign sample        = (state_q == ACTIVE) && mac_out_valid_i;
   assign wf_end        = (w_q == wlast_q);
   assign last_wf       = sample && wf_end && (t_q == klast_q);
   assign w_total       = 32'(instr_v_dim_i) + 32'(MUL_SIZE) - 32'd1;
   assign illegal       = (instr_v_dim_i == '0) || (instr_k_tiles_i == '0) ||
                          (w_total > 32'(BANK_DEPTH));
   assign instr_ready_o = ((state_q == IDLE) || last_wf) && !busy_q[next_bank_q];
   assign accept        = instr_valid_i && instr_ready_o;
   assign accept_ok     = accept && !illegal;
   assign accept_err    = accept && illegal;
   assign add_now       = acc_q || (t_q != '0);
   assign addr_now      = {bank_q, w_q[ROW_W-1:0]};

   // Lane k (MSB first) holds a valid partial sum while k <= w < k+V.
   always_comb begin
      mask_now = '0;
      for (int k = 0; k < MUL_SIZE; k++) begin
         if ((w_q >= CNT_W'(k)) && (w_q < CNT_W'(k) + CNT_W'(v_q)))
            mask_now[MUL_SIZE-1-k] = 1'b1;
      end
   end

   // Next-state: counter advance, instruction accept, bank claim and release.
   always_comb begin
      state_d     = state_q;
      w_d         = w_q;
      t_d         = t_q;
      wlast_d     = wlast_q;
      klast_d     = klast_q;
      v_d         = v_q;
      acc_d       = acc_q;
      bank_d      = bank_q;
      next_bank_d = next_bank_q;
      busy_d      = busy_q;

      if (bank_release_i)
         busy_d[bank_release_id_i] = 1'b0;

      if (sample) begin
         if (last_wf) begin
            state_d = IDLE;
         end else if (wf_end) begin
            w_d = '0;
            t_d = t_q + DIM_W'(1);
         end else begin
            w_d = w_q + CNT_W'(1);
         end
      end

      // A legal accept on the last wavefront overrides the return to IDLE.
      if (accept_ok) begin
         state_d             = ACTIVE;
         w_d                 = '0;
         t_d                 = '0;
         v_d                 = instr_v_dim_i;
         klast_d             = instr_k_tiles_i - DIM_W'(1);
         wlast_d             = CNT_W'(w_total - 32'd1);
         acc_d               = instr_accumulate_i;
         bank_d              = next_bank_q;
         next_bank_d         = next_bank_q + BID_W'(1);
         busy_d[next_bank_q] = 1'b1;
      end
   end

   // Control state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         w_q         <= '0;
         t_q         <= '0;
         wlast_q     <= '0;
         klast_q     <= '0;
         v_q         <= '0;
         acc_q       <= 1'b0;
         bank_q      <= '0;
         next_bank_q <= '0;
         busy_q      <= '0;
      end else begin
         state_q     <= state_d;
         w_q         <= w_d;
         t_q         <= t_d;
         wlast_q     <= wlast_d;
         klast_q     <= klast_d;
         v_q         <= v_d;
         acc_q       <= acc_d;
         bank_q      <= bank_d;
         next_bank_q <= next_bank_d;
         busy_q      <= busy_d;
      end
   end

   // Command pipeline: read at c+1, write at c+2, done at c+3; reset flushes it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_rd_en_o    <= 1'b0;
         acc_rd_addr_o  <= '0;
         acc_rd_mask_o  <= '0;
         acc_wr_en_o    <= 1'b0;
         acc_wr_addr_o  <= '0;
         acc_wr_mask_o  <= '0;
         acc_add_o      <= 1'b0;
         bank_done_o    <= 1'b0;
         bank_done_id_o <= '0;
         instr_err_o    <= 1'b0;
         p1_valid       <= 1'b0;
         p1_add         <= 1'b0;
         p1_last        <= 1'b0;
         p1_bank        <= '0;
         p2_last        <= 1'b0;
         p2_bank        <= '0;
      end else begin
         acc_rd_en_o <= sample && add_now;
         p1_valid    <= sample;
         p1_last     <= last_wf;
         if (sample) begin
            acc_rd_addr_o <= addr_now;
            acc_rd_mask_o <= mask_now;
            p1_add        <= add_now;
            p1_bank       <= bank_q;
         end

         acc_wr_en_o <= p1_valid;
         if (p1_valid) begin
            acc_wr_addr_o <= acc_rd_addr_o;
            acc_wr_mask_o <= acc_rd_mask_o;
            acc_add_o     <= p1_add;
         end

         // Each stage carries its own last flag, so overlapped completions stay separate pulses.
         p2_last     <= p1_valid && p1_last;
         p2_bank     <= p1_bank;
         bank_done_o <= p2_last;
         if (p2_last)
            bank_done_id_o <= p2_bank;

         instr_err_o <= accept_err;
      end
   end

endmodule

// File: tb/tb_accum_ctrl_banked.sv
// tb/tb_accum_ctrl_banked.sv - self-checking bench for accum_ctrl_banked
module tb_accum_ctrl_banked;

   localparam int MS = 32;
   localparam int DW = 10;
   localparam int AW = 10;
   localparam int NB = 2;
   localparam int BD = 512;
   localparam int RS = 8;

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b0;
   logic             instr_valid_i = 1'b0;
   logic             instr_ready_o;
   logic [DW-1:0]    instr_v_dim_i = '0;
   logic [DW-1:0]    instr_k_tiles_i = '0;
   logic             instr_accumulate_i = 1'b0;
   logic             mac_out_valid_i = 1'b0;
   logic             acc_rd_en_o;
   logic [AW-1:0]    acc_rd_addr_o;
   logic [MS-1:0]    acc_rd_mask_o;
   logic             acc_wr_en_o;
   logic [AW-1:0]    acc_wr_addr_o;
   logic [MS-1:0]    acc_wr_mask_o;
   logic             acc_add_o;
   logic             bank_done_o;
   logic [0:0]       bank_done_id_o;
   logic             bank_release_i = 1'b0;
   logic [0:0]       bank_release_id_i = '0;
   logic             instr_err_o;

   always #5 clk_i = ~clk_i;

   accum_ctrl_banked #(.MUL_SIZE(MS), .DIM_W(DW), .ADDR_W(AW), .NUM_BANKS(NB)) dut (
      .clk_i              (clk_i),
      .rst_ni             (rst_ni),
      .instr_valid_i      (instr_valid_i),
      .instr_ready_o      (instr_ready_o),
      .instr_v_dim_i      (instr_v_dim_i),
      .instr_k_tiles_i    (instr_k_tiles_i),
      .instr_accumulate_i (instr_accumulate_i),
      .mac_out_valid_i    (mac_out_valid_i),
      .acc_rd_en_o        (acc_rd_en_o),
      .acc_rd_addr_o      (acc_rd_addr_o),
      .acc_rd_mask_o      (acc_rd_mask_o),
      .acc_wr_en_o        (acc_wr_en_o),
      .acc_wr_addr_o      (acc_wr_addr_o),
      .acc_wr_mask_o      (acc_wr_mask_o),
      .acc_add_o          (acc_add_o),
      .bank_done_o        (bank_done_o),
      .bank_done_id_o     (bank_done_id_o),
      .bank_release_i     (bank_release_i),
      .bank_release_id_i  (bank_release_id_i),
      .instr_err_o        (instr_err_o)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: bank ownership, current instruction as a flat wavefront index,
   // and a ring of expected outputs per future cycle.
   int          busy [NB];
   int          nb;
   bit          active;
   int          cur_bank, cur_v, cur_k, cur_acc, cur_n, cur_wf;
   bit          s_rd [RS], s_wr [RS], s_add [RS], s_done [RS], s_err [RS];
   int          s_rd_addr [RS], s_wr_addr [RS], s_id [RS];
   logic [31:0] s_rd_mask [RS], s_wr_mask [RS];
   int          slot = 0;
   bit          last_acc;

   int          n_wr, n_rd, n_err;
   int          done_ids [$];
   logic [31:0] wr_masks [$];
   int          wr_addrs [$];

   typedef struct {
      int v; int k; int acc; int err; int wr; int rd; int done;
   } vec_t;
   vec_t tbl [10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at step %0d: got 0x%0h, expected 0x%0h", name, slot, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_mask(input int w, input int v);
      logic [31:0] m = 32'h0;
      int lo = (w - v + 1 > 0) ? (w - v + 1) : 0;
      int hi = (w < MS - 1) ? w : (MS - 1);
      for (int k = lo; k <= hi; k++) m[MS-1-k] = 1'b1;
      return m;
   endfunction

   task automatic clear_model();
      for (int j = 0; j < RS; j++) begin
         s_rd[j] = 0; s_wr[j] = 0; s_add[j] = 0; s_done[j] = 0; s_err[j] = 0;
      end
      for (int b = 0; b < NB; b++) busy[b] = 0;
      nb = 0; active = 0; cur_wf = 1; cur_k = 1; cur_n = 0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rd_en"},   acc_rd_en_o, 0);
      chk({tag, "_rd_addr"}, acc_rd_addr_o, 0);
      chk({tag, "_rd_mask"}, acc_rd_mask_o, 0);
      chk({tag, "_wr_en"},   acc_wr_en_o, 0);
      chk({tag, "_wr_addr"}, acc_wr_addr_o, 0);
      chk({tag, "_wr_mask"}, acc_wr_mask_o, 0);
      chk({tag, "_add"},     acc_add_o, 0);
      chk({tag, "_done"},    bank_done_o, 0);
      chk({tag, "_done_id"}, bank_done_id_o, 0);
      chk({tag, "_err"},     instr_err_o, 0);
   endtask

   // One clock: check registered outputs due now, drive inputs, check ready, advance model.
   task automatic step(input bit iv, input int v, input int k, input bit acc,
                       input bit mv, input bit rel, input int rid);
      int j, j1, j2, j3, w, t, total;
      bit exp_ready, add;
      @(negedge clk_i);
      j = slot % RS;
      if (acc_wr_en_o) begin n_wr++; wr_masks.push_back(acc_wr_mask_o); wr_addrs.push_back(int'(acc_wr_addr_o)); end
      if (acc_rd_en_o) n_rd++;
      if (instr_err_o) n_err++;
      if (bank_done_o) done_ids.push_back(int'(bank_done_id_o));
      chk("rd_en", acc_rd_en_o, s_rd[j]);
      if (s_rd[j]) begin
         chk("rd_addr", acc_rd_addr_o, s_rd_addr[j]);
         chk("rd_mask", acc_rd_mask_o, s_rd_mask[j]);
      end
      chk("wr_en", acc_wr_en_o, s_wr[j]);
      if (s_wr[j]) begin
         chk("wr_addr", acc_wr_addr_o, s_wr_addr[j]);
         chk("wr_mask", acc_wr_mask_o, s_wr_mask[j]);
         chk("wr_add", acc_add_o, s_add[j]);
      end
      chk("done", bank_done_o, s_done[j]);
      if (s_done[j]) chk("done_id", bank_done_id_o, s_id[j]);
      chk("err", instr_err_o, s_err[j]);
      s_rd[j] = 0; s_wr[j] = 0; s_add[j] = 0; s_done[j] = 0; s_err[j] = 0;

      instr_valid_i      = iv;
      instr_v_dim_i      = DW'(v);
      instr_k_tiles_i    = DW'(k);
      instr_accumulate_i = acc;
      mac_out_valid_i    = mv;
      bank_release_i     = rel;
      bank_release_id_i  = 1'(rid);
      #1;
      total = cur_wf * cur_k;
      exp_ready = (!active || (mv && cur_n == total - 1)) && (busy[nb] == 0);
      chk("ready", instr_ready_o, exp_ready);
      last_acc = iv && exp_ready;

      j1 = (slot + 1) % RS; j2 = (slot + 2) % RS; j3 = (slot + 3) % RS;
      if (active && mv) begin
         w = cur_n % cur_wf;
         t = cur_n / cur_wf;
         add = (t > 0) || (cur_acc != 0);
         s_rd[j1] = add;
         s_rd_addr[j1] = cur_bank * BD + w;
         s_rd_mask[j1] = exp_mask(w, cur_v);
         s_wr[j2] = 1;
         s_wr_addr[j2] = cur_bank * BD + w;
         s_wr_mask[j2] = exp_mask(w, cur_v);
         s_add[j2] = add;
         if (cur_n == total - 1) begin
            s_done[j3] = 1; s_id[j3] = cur_bank; active = 0;
         end
         cur_n++;
      end
      if (rel) busy[rid] = 0;
      if (last_acc) begin
         if (v == 0 || k == 0 || (v + MS - 1 > BD)) begin
            s_err[j1] = 1;
         end else begin
            active = 1; cur_bank = nb; cur_v = v; cur_k = k; cur_acc = acc;
            cur_wf = v + MS - 1; cur_n = 0; busy[nb] = 1; nb = (nb + 1) % NB;
         end
      end
      slot++;
   endtask

   task automatic issue(input int v, input int k, input bit acc);
      int n = 0;
      last_acc = 0;
      while (!last_acc && n < 64) begin
         step(1, v, k, acc, 0, 0, 0);
         n++;
      end
      chk("accept_timeout", last_acc, 1);
   endtask

   task automatic drain(input int gap);
      int cnt = 0;
      while (active && cnt < 20000) begin
         step(0, 0, 0, 0, (gap == 0) || ((cnt % (3 + gap)) < 3), 0, 0);
         cnt++;
      end
      chk("drain_timeout", active, 0);
      repeat (4) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic release_all();
      step(0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 1, 1);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      instr_valid_i = 0; mac_out_valid_i = 0; bank_release_i = 0;
      #2;
      rst_ni = 1'b0;
      #1;
      chk_zero("rst_async");
      clear_model();
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   initial begin
      int got;
      clear_model();
      tbl[0] = '{4,   1, 0, 0, 35,  0,   1};
      tbl[1] = '{32,  3, 0, 0, 189, 126, 1};
      tbl[2] = '{7,   2, 1, 0, 76,  76,  1};
      tbl[3] = '{1,   1, 0, 0, 32,  0,   1};
      tbl[4] = '{0,   2, 0, 1, 0,   0,   0};
      tbl[5] = '{5,   0, 1, 1, 0,   0,   0};
      tbl[6] = '{490, 1, 0, 1, 0,   0,   0};
      tbl[7] = '{482, 1, 0, 1, 0,   0,   0};
      tbl[8] = '{481, 1, 0, 0, 512, 0,   1};
      tbl[9] = '{255, 1, 1, 0, 286, 286, 1};

      repeat (2) @(negedge clk_i);
      chk_zero("reset");
      rst_ni = 1'b1;

      // Table of single instructions, including illegal ones and the W=BANK_DEPTH boundary.
      for (int i = 0; i < 10; i++) begin
         n_wr = 0; n_rd = 0; n_err = 0;
         done_ids.delete(); wr_masks.delete(); wr_addrs.delete();
         issue(tbl[i].v, tbl[i].k, tbl[i].acc[0]);
         drain(0);
         chk("tbl_writes", n_wr, tbl[i].wr);
         chk("tbl_reads", n_rd, tbl[i].rd);
         chk("tbl_err", n_err, tbl[i].err);
         chk("tbl_done", done_ids.size(), tbl[i].done);
         if (i == 0) begin
            chk("mask_w0",  wr_masks.size() > 0  ? wr_masks[0]  : 32'hDEAD, 32'h80000000);
            chk("mask_w3",  wr_masks.size() > 3  ? wr_masks[3]  : 32'hDEAD, 32'hF0000000);
            chk("mask_w31", wr_masks.size() > 31 ? wr_masks[31] : 32'hDEAD, 32'h0000000F);
            chk("mask_w34", wr_masks.size() > 34 ? wr_masks[34] : 32'hDEAD, 32'h00000001);
            chk("addr_w34", wr_addrs.size() > 34 ? wr_addrs[34] : -1, 34);
         end
         release_all();
      end

      // Multi-tile with 5-cycle gaps in the wavefront stream.
      issue(32, 3, 0);
      drain(5);
      release_all();

      // Reset in the middle of a tile.
      issue(8, 2, 1);
      repeat (30) step(0, 0, 0, 0, 1, 0, 0);
      do_reset();
      step(0, 0, 0, 0, 0, 0, 0);
      chk("post_reset_ready", instr_ready_o, 1);
      done_ids.delete(); wr_addrs.delete();
      issue(5, 1, 0);
      drain(0);
      chk("post_reset_done_cnt", done_ids.size(), 1);
      chk("post_reset_done_id", done_ids.size() > 0 ? done_ids[0] : -1, 0);
      chk("post_reset_addr0", wr_addrs.size() > 0 ? wr_addrs[0] : -1, 0);
      do_reset();

      // Back-to-back: second instruction offered only on the first one's last wavefront.
      done_ids.delete(); wr_addrs.delete();
      issue(4, 1, 0);
      got = 0;
      for (int n = 0; n < 200; n++) begin
         bit lastw;
         lastw = active && (cur_n == cur_wf * cur_k - 1);
         step(lastw, 6, 1, 1, 1, 0, 0);
         if (lastw) begin got = last_acc; break; end
      end
      chk("b2b_accept", got, 1);
      drain(0);
      chk("b2b_done_cnt", done_ids.size(), 2);
      chk("b2b_done0", done_ids.size() > 0 ? done_ids[0] : -1, 0);
      chk("b2b_done1", done_ids.size() > 1 ? done_ids[1] : -1, 1);
      chk("b2b_base", wr_addrs.size() > 35 ? wr_addrs[35] : -1, 512);
      release_all();

      // Bank exhaustion, free-bank release, and release-to-ready latency.
      issue(3, 1, 0);
      drain(0);
      step(0, 0, 0, 0, 0, 1, 1);
      issue(3, 1, 0);
      drain(0);
      for (int n = 0; n < 4; n++) begin
         step(1, 3, 1, 0, 0, 0, 0);
         chk("exhaust_stall", instr_ready_o, 0);
      end
      step(1, 3, 1, 0, 0, 1, 0);
      chk("release_same_cycle", instr_ready_o, 0);
      step(1, 3, 1, 0, 0, 0, 0);
      chk("release_next_ready", instr_ready_o, 1);
      chk("release_accept", last_acc, 1);
      wr_addrs.delete();
      drain(0);
      chk("exhaust_bank0", wr_addrs.size() > 0 ? wr_addrs[0] : -1, 0);
      release_all();

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         int rv;
         rv = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 40));
         step($urandom_range(0, 3) == 0, rv, int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
              $urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0, int'($urandom_range(0, 1)));
      end
      drain(0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
